if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the synchronous instruction memory.
- Generates the word address each cycle and tracks the PC of the one request in flight.
- Captures the memory's registered instruction into the IF/ID pipeline register.
- Handles pipeline stall (hold, no lost instruction) and EX-stage redirect (branch/jump flush).

Parameters:
- RESET_PC, 32'h0000_0000: byte address fetched first after reset.
- ADDR_W, 5: instruction-memory word-index width (depth 2^ADDR_W = 32 words).
- NOP_INSTR, 32'h0000_0013: value driven on id_instr when the slot is invalid (addi x0,x0,0).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- imem_addr  output  ADDR_W  word index to instruction memory; combinational.
- imem_instr  input  32  instruction memory data, valid one cycle after imem_addr was presented at a clk edge.
- stall  input  1  hazard unit: hold IF and IF/ID this cycle.
- redirect_valid  input  1  EX stage: branch taken or jump.
- redirect_pc  input  32  target byte address; bits [1:0] ignored.
- id_instr  output  32  IF/ID instruction.
- id_pc  output  32  IF/ID byte PC of id_instr.
- id_valid  output  1  IF/ID slot holds a real instruction.

Behaviour:
- Internal registers:
  - pc_f: next byte address to issue.
  - req_pc / req_v: address issued at the last edge whose data is now on imem_instr.
- Reset (async, immediate): pc_f=RESET_PC, req_pc=0, req_v=0, id_instr=NOP_INSTR, id_pc=0, id_valid=0.
- imem_addr, combinational, priority order:
  - redirect_valid: redirect_pc[ADDR_W+1:2]
  - else stall: req_pc[ADDR_W+1:2] (re-read the in-flight word)
  - else: pc_f[ADDR_W+1:2]
- Addresses beyond memory depth wrap (upper bits dropped); no error flag.
- Per-edge update, priority redirect > stall > run:
  - REDIRECT:
    - id_valid<=0, id_instr<=NOP_INSTR, id_pc<=0 (flush).
    - req_pc<={redirect_pc[31:2],2'b00}, req_v<=1.
    - pc_f<={redirect_pc[31:2],2'b00}+4.
    - The in-flight word is discarded.
  - STALL:
    - id_* hold; pc_f, req_pc, req_v hold.
    - Memory re-reads req_pc, so imem_instr still matches req_pc when the stall releases.
  - RUN:
    - id_instr<= req_v ? imem_instr : NOP_INSTR; id_pc<=req_pc; id_valid<=req_v.
    - req_pc<=pc_f, req_v<=1; pc_f<=pc_f+4.
- Derived FSM on (req_v, stall):
  - BOOT (req_v=0): first cycle after reset release.
  - BOOT → RUN on the next edge unless stalled.
  - RUN → HOLD when stall=1; HOLD → RUN when stall=0.
  - Any state → RUN on redirect (req_v=1).
- Latency:
  - First valid id_valid two edges after rst deasserts: edge 1 issues RESET_PC, edge 2 captures it.
  - Redirect penalty: id_valid=0 for exactly one cycle, then target valid on the following edge.
- Throughput: one instruction per cycle without stall/redirect.
- pc_f+4 wraps modulo 2^32.
- imem_instr may be high-Z after memory reset. It is never propagated because req_v=0 forces NOP_INSTR.
- Simultaneous stall and redirect: redirect wins; the flush occurs even though ID requested a hold.
- rst asserted mid-operation: all state returns to reset values asynchronously; any in-flight request is dropped.

Decomposition:
- Shared package rv32_pkg:
  - NOP_INSTR constant.
  - XLEN=32.
  - PC increment constant 4.
  - IF/ID struct/typedef {instr, pc, valid}, reused by the decode stage.
- One natural sub-module: if_id_reg, the IF/ID register with hold/flush/load controls. The PC/request logic stays in the top.

Test Plan:
- Reset release with mem[0..3]=A0..A3, no stall:
  - id_valid=0 after edge 1.
  - Edge 2: id_instr=A0, id_pc=0, id_valid=1.
  - Edge 3: A1/4; edge 4: A2/8.
- Stall for 3 cycles while id holds A1/4:
  - id_* unchanged for 3 edges; imem_addr=2 during stall.
  - First edge after release: A2/8; next edge: A3/12. No skip, no duplicate.
- Redirect to 0x14 while id holds A1:
  - Next edge: id_valid=0, id_instr=0x00000013.
  - Following edge: id_instr=mem[5], id_pc=0x14; then mem[6]/0x18.
- stall=1 and redirect_valid=1 (target 0x8) in the same cycle:
  - Flush occurs (id_valid=0); next edge: mem[2]/0x8.
- Redirect to 0x7C (last word, depth 32), then run:
  - id_pc sequence 0x7C, 0x80.
  - imem_addr wraps 31→0, so id_instr=mem[0] at id_pc=0x80.
- Assert rst asynchronously mid-stream (not on an edge):
  - id_valid=0 and id_instr=0x00000013 immediately.
  - After release, fetch restarts at RESET_PC with two-edge latency.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types and constants used by fetch and decode.
// No logic; latency and backpressure are defined by the stages importing it.
package rv32_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_INC    = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            valid;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one edge of latency, flush beats hold beats load.
// Backpressure: hold freezes the slot; flush inserts a NOP bubble.
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             flush,
   input  rv32_pkg::if_id_t d,
   output rv32_pkg::if_id_t q
);
   import rv32_pkg::*;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
      end else if (flush) begin
         q <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues a word address each cycle to a synchronous imem and fills IF/ID.
// First instruction two edges after reset, one per cycle; stall holds everything, redirect flushes.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          ADDR_W    = 5,
   parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_instr,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic [31:0]       id_instr,
   output logic [31:0]       id_pc,
   output logic              id_valid
);
   import rv32_pkg::*;

   logic [31:0] pc_f;
   logic [31:0] req_pc;
   logic        req_v;
   logic [31:0] redirect_base;
   logic [1:0]  unused_redirect_lsbs;
   if_id_t      id_d;
   if_id_t      id_q;

   assign redirect_base        = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = redirect_pc[1:0];

   // While stalled the memory re-reads the in-flight word, so its data is still valid on release.
   always_comb begin
      if (redirect_valid)
         imem_addr = redirect_pc[ADDR_W+1:2];
      else if (stall)
         imem_addr = req_pc[ADDR_W+1:2];
      else
         imem_addr = pc_f[ADDR_W+1:2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_f   <= RESET_PC;
         req_pc <= '0;
         req_v  <= 1'b0;
      end else if (redirect_valid) begin
         req_pc <= redirect_base;
         req_v  <= 1'b1;
         pc_f   <= redirect_base + PC_INC;
      end else if (!stall) begin
         req_pc <= pc_f;
         req_v  <= 1'b1;
         pc_f   <= pc_f + PC_INC;
      end
   end

   // req_v gates imem_instr so undriven memory output after reset never reaches ID.
   always_comb begin
      id_d.instr = req_v ? imem_instr : NOP_INSTR;
      id_d.pc    = req_pc;
      id_d.valid = req_v;
   end

   if_id_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id (
      .clk   (clk),
      .rst   (rst),
      .hold  (stall),
      .flush (redirect_valid),
      .d     (id_d),
      .q     (id_q)
   );

   assign id_instr = id_q.instr;
   assign id_pc    = id_q.pc;
   assign id_valid = id_q.valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with a 32-word synchronous memory model.
module tb_if_fetch_unit;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_valid;

   logic [31:0] mem [32];
   if_id_t      exp_q [$];
   if_id_t      e;
   int          checks;
   int          failures;

   always #5 clk = ~clk;

   always @(posedge clk) imem_instr <= mem[imem_addr];

   if_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_valid       (id_valid)
   );

   function automatic if_id_t fetched(input logic [31:0] pc);
      logic [4:0] w;
      w = pc[6:2];
      return '{instr: mem[w], pc: pc, valid: 1'b1};
   endfunction

   function automatic if_id_t bubble();
      return '{instr: 32'h0000_0013, pc: 32'h0, valid: 1'b0};
   endfunction

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      e = bubble();
      checks++;
      if ({id_instr, id_pc, id_valid} !== e) begin
         failures++;
         $display("FAIL reset_state: got %h/%h/%b want %h/%h/%b", id_instr, id_pc, id_valid, e.instr, e.pc, e.valid);
      end
      checks++;
      if (imem_addr !== 5'd0) begin
         failures++;
         $display("FAIL reset_addr: got %0d want 0", imem_addr);
      end
      #3 rst = 1'b0;
      exp_q.push_back(bubble());
      exp_q.push_back(fetched(32'h0));
      exp_q.push_back(fetched(32'h4));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({id_instr, id_pc, id_valid} !== e) begin
            failures++;
            $display("FAIL boot edge%0d: got %h/%h/%b want %h/%h/%b", i + 1, id_instr, id_pc, id_valid, e.instr, e.pc, e.valid);
         end
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      #1;
      checks++;
      if (imem_addr !== 5'd2) begin
         failures++;
         $display("FAIL stall_addr: got %0d want 2", imem_addr);
      end
      repeat (3) exp_q.push_back(fetched(32'h4));
      exp_q.push_back(fetched(32'h8));
      exp_q.push_back(fetched(32'hC));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i < 2) begin
            checks++;
            if (imem_addr !== 5'd2) begin
               failures++;
               $display("FAIL stall_addr_hold edge%0d: got %0d want 2", i, imem_addr);
            end
         end
         if (i == 2) stall = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({id_instr, id_pc, id_valid} !== e) begin
            failures++;
            $display("FAIL stall edge%0d: got %h/%h/%b want %h/%h/%b", i, id_instr, id_pc, id_valid, e.instr, e.pc, e.valid);
         end
      end
   endtask

   task automatic test_redirect();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h17;
      #1;
      checks++;
      if (imem_addr !== 5'd5) begin
         failures++;
         $display("FAIL redirect_addr: got %0d want 5", imem_addr);
      end
      exp_q.push_back(bubble());
      exp_q.push_back(fetched(32'h14));
      exp_q.push_back(fetched(32'h18));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         redirect_valid = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({id_instr, id_pc, id_valid} !== e) begin
            failures++;
            $display("FAIL redirect edge%0d: got %h/%h/%b want %h/%h/%b", i, id_instr, id_pc, id_valid, e.instr, e.pc, e.valid);
         end
      end
   endtask

   task automatic test_stall_and_redirect();
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8;
      exp_q.push_back(bubble());
      exp_q.push_back(fetched(32'h8));
      exp_q.push_back(fetched(32'hC));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         stall = 1'b0; redirect_valid = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if ({id_instr, id_pc, id_valid} !== e) begin
            failures++;
            $display("FAIL stall_redirect edge%0d: got %h/%h/%b want %h/%h/%b", i, id_instr, id_pc, id_valid, e.instr, e.pc, e.valid);
         end
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'h7C;
      exp_q.push_back(bubble());
      exp_q.push_back('{instr: mem[31], pc: 32'h7C, valid: 1'b1});
      exp_q.push_back('{instr: mem[0], pc: 32'h80, valid: 1'b1});
      exp_q.push_back(bubble());
      exp_q.push_back('{instr: mem[31], pc: 32'hFFFF_FFFC, valid: 1'b1});
      exp_q.push_back('{instr: mem[0], pc: 32'h0, valid: 1'b1});
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         redirect_valid = (i == 2);
         if (i == 2) redirect_pc = 32'hFFFF_FFFC;
         e = exp_q.pop_front();
         checks++;
         if ({id_instr, id_pc, id_valid} !== e) begin
            failures++;
            $display("FAIL wrap edge%0d: got %h/%h/%b want %h/%h/%b", i, id_instr, id_pc, id_valid, e.instr, e.pc, e.valid);
         end
      end
   endtask

   task automatic test_async_reset();
      #2 rst = 1'b1;
      #1;
      e = bubble();
      checks++;
      if ({id_instr, id_pc, id_valid} !== e) begin
         failures++;
         $display("FAIL async_reset: got %h/%h/%b want %h/%h/%b", id_instr, id_pc, id_valid, e.instr, e.pc, e.valid);
      end
      checks++;
      if (imem_addr !== 5'd0) begin
         failures++;
         $display("FAIL async_reset_addr: got %0d want 0", imem_addr);
      end
      @(posedge clk); #4;
      rst = 1'b0;
      exp_q.push_back(bubble());
      exp_q.push_back(fetched(32'h0));
      exp_q.push_back(fetched(32'h4));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if ({id_instr, id_pc, id_valid} !== e) begin
            failures++;
            $display("FAIL restart edge%0d: got %h/%h/%b want %h/%h/%b", i + 1, id_instr, id_pc, id_valid, e.instr, e.pc, e.valid);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0101;
      test_reset();
      test_stall();
      test_redirect();
      test_stall_and_redirect();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
